// File: rtl/ifetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ifetch_unit : single-outstanding instruction fetch FSM with redirect/drain
// Rev 1.0
// ============================================================================
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_data_q, inst_data_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        armed_q;
   logic        req_valid_q;
   logic        inst_valid_q;
   logic [31:0] w_redir_pc;

   assign w_redir_pc = {redirect_pc[31:2], 2'b00};

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      inst_data_d = inst_data_q;
      inst_pc_d   = inst_pc_q;
      if (redirect_valid) begin
         pc_d = w_redir_pc;
      end
      case (state_q)
         // armed_q holds IDLE for one full cycle after reset release
         S_IDLE: begin
            if (redirect_valid || armed_q) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (imem_req_ready) begin
               state_d = redirect_valid ? S_DRAIN : S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               state_d = imem_resp_valid ? S_REQ : S_DRAIN;
            end else if (imem_resp_valid) begin
               inst_data_d = imem_resp_data;
               inst_pc_d   = pc_q;
               pc_d        = pc_q + 32'd4;
               state_d     = S_HOLD;
            end
         end
         S_HOLD: begin
            if (redirect_valid || inst_ready) begin
               state_d = S_REQ;
            end
         end
         S_DRAIN: begin
            if (imem_resp_valid) begin
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         inst_data_q  <= 32'd0;
         inst_pc_q    <= 32'd0;
         armed_q      <= 1'b0;
         req_valid_q  <= 1'b0;
         inst_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_data_q  <= inst_data_d;
         inst_pc_q    <= inst_pc_d;
         armed_q      <= 1'b1;
         req_valid_q  <= (state_d == S_REQ);
         inst_valid_q <= (state_d == S_HOLD);
      end
   end

   assign imem_req_valid = req_valid_q;
   assign imem_req_addr  = pc_q;
   assign inst_valid     = inst_valid_q;
   assign inst_data      = inst_data_q;
   assign inst_pc        = inst_pc_q;

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001: Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset; bits [1:0] SHALL be zero.
REQ-002: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003: rst  input  1  reset, asynchronous, active-high.
REQ-004: redirect_valid  input  1  branch/jump redirect strobe from execute.
REQ-005: redirect_pc  input  32  redirect target.
REQ-006: imem_req_valid  output  1  instruction-memory request valid.
REQ-007: imem_req_ready  input  1  memory accepts request this cycle.
REQ-008: imem_req_addr  output  32  request word address (byte address, bits [1:0]=0).
REQ-009: imem_resp_valid  input  1  response data valid; exactly one response per accepted request, any latency >=1 cycle.
REQ-010: imem_resp_data  input  32  instruction word.
REQ-011: inst_valid  output  1  instruction available to decode.
REQ-012: inst_ready  input  1  decode accepts instruction.
REQ-013: inst_data  output  32  fetched instruction.
REQ-014: inst_pc  output  32  address of inst_data.

Function
REQ-015: States SHALL be IDLE, REQ, WAIT, HOLD, DRAIN; at most one request outstanding.
REQ-016: IDLE: all valid outputs 0; SHALL go to REQ on the next clock.
REQ-017: REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready SHALL go to WAIT.
REQ-018: WAIT: on imem_resp_valid, SHALL latch inst_data<=imem_resp_data, inst_pc<=pc, pc<=pc+4, go to HOLD.
REQ-019: HOLD: inst_valid=1, inst_data/inst_pc stable; on inst_ready SHALL go to REQ (one instruction per 3 cycles minimum with 1-cycle memory).
REQ-020: imem_req_valid SHALL be 1 only in REQ; inst_valid SHALL be 1 only in HOLD.
REQ-021: pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022: Redirect SHALL take priority over every other event in the same cycle; pc<={redirect_pc[31:2],2'b00} (low bits silently cleared).
REQ-023: Redirect in IDLE, REQ (without imem_req_ready), HOLD, or DRAIN-with-resp SHALL go to REQ; held instruction dropped, inst_valid=0 next cycle.
REQ-024: Redirect in REQ with imem_req_ready=1, or in WAIT without imem_resp_valid, SHALL go to DRAIN (response still owed).
REQ-025: Redirect in WAIT with imem_resp_valid=1 SHALL discard that response and go to REQ.
REQ-026: DRAIN: outputs invalid; on imem_resp_valid SHALL discard data and go to REQ; further redirects in DRAIN only update pc.
REQ-027: In HOLD, redirect and inst_ready in the same cycle: handshake completes (instruction consumed), pc from redirect.
REQ-028: imem_req_addr MAY change while imem_req_valid=1 only due to redirect.
REQ-029: imem_resp_valid outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-030: While rst=1: state=IDLE, pc=RESET_PC, imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0, imem_req_addr=RESET_PC, regardless of clk.
REQ-031: rst asserted mid-transaction SHALL abandon any outstanding request without draining; memory side is reset concurrently.
REQ-032: First imem_req_valid SHALL assert the second rising edge after rst deasserts (one IDLE cycle).

Verification
REQ-033: Reset release, mem ready always, 1-cycle response, inst_ready=1 -> addresses 0x0,0x4,0x8 issued in order; inst_pc/inst_data match memory image.
REQ-034: inst_ready=0 for 5 cycles in HOLD -> inst_valid stays 1, inst_data/inst_pc unchanged, no new imem request.
REQ-035: Redirect to 0x100 while in WAIT (response 3 cycles later) -> DRAIN, stale response discarded, next request addr 0x100, first delivered inst_pc=0x100.
REQ-036: Redirect to 0x203 coincident with imem_resp_valid in WAIT -> response dropped, next request addr 0x200.
REQ-037: pc=0xFFFF_FFFC fetched and consumed -> next request addr 0x0000_0000.
REQ-038: rst pulsed asynchronously (between edges) during WAIT -> outputs return to reset values immediately; fetch restarts at RESET_PC after one IDLE cycle.
